// File: rtl/shift_pkg.sv
// Shared widths, shift operation codes and sequencer states for the shift sequencer.
package shift_pkg;
  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;

  typedef enum logic [1:0] {
    SHIFT_NONE = 2'b00,
    SHIFT_LSL  = 2'b01,
    SHIFT_LSR  = 2'b10,
    SHIFT_ASR  = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } seq_state_t;
endpackage

// File: rtl/shifter.sv
// Single-position combinational shifter: zero latency, no flow control.
module shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] shift_in,
  input  shift_op_t         shift_op,
  output logic [DATA_W-1:0] shift_out
);

  always_comb begin
    case (shift_op)
      SHIFT_LSL: shift_out = {shift_in[DATA_W-2:0], 1'b0};
      SHIFT_LSR: shift_out = {1'b0, shift_in[DATA_W-1:1]};
      SHIFT_ASR: shift_out = {shift_in[DATA_W-1], shift_in[DATA_W-1:1]};
      default:   shift_out = shift_in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Variable-amount shift by iterating the shifter once per clock; result after N+1 cycles.
// Accepts only in IDLE; result held in DONE until out_ready.
module shift_sequencer
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_op,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              cancel,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  seq_state_t        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  shift_op_t         op_q, op_d;
  logic [AMT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_out;

  shifter u_shifter (
    .shift_in  (data_q),
    .shift_op  (op_q),
    .shift_out (shift_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          data_d = in_data;
          op_d   = shift_op_t'(in_op);
          cnt_d  = in_amt;
          // Nothing to iterate: present the operand unchanged next cycle.
          if (in_amt == '0 || shift_op_t'(in_op) == SHIFT_NONE) state_d = DONE;
          else                                                  state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          data_d = shift_out;
          cnt_d  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= SHIFT_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q == SHIFT) || (state_q == DONE);
  assign out_valid   = (state_q == DONE);
  assign out_data    = data_q;

endmodule
